i2c_init_sequencer: RTL



---
 rtl/i2c_init_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/i2c_init_sequencer.sv
// rtl/i2c_init_sequencer.sv - WM8731 power-up register sequencer driving the I2C controller
module i2c_init_sequencer #(
  parameter int NUM_CMDS       = 7,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int MAX_RETRY      = 3,
  localparam int IW = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_i2c_finished,
  output logic [23:0]   o_i2c_data,
  output logic          o_i2c_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_error,
  output logic [IW-1:0] o_index
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 1) > 0 ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [23:0] CMD_TABLE [0:6] = '{
    24'h341E00, 24'h340815, 24'h340A00, 24'h340C00,
    24'h340E42, 24'h341019, 24'h341201
  };

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, DONE, ERROR} state_t;

  state_t        state, state_d;
  logic [IW-1:0] idx, idx_d;
  logic [RW-1:0] retry, retry_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic [GW-1:0] gcnt, gcnt_d;
  logic          fin_q;
  logic          fin_rise;

  // A level already high when WAIT begins is stale; only a fresh rise counts.
  assign fin_rise = i_i2c_finished & ~fin_q;
  assign o_index  = idx;

  always_comb begin
    state_d = state;
    idx_d   = idx;
    retry_d = retry;
    tcnt_d  = tcnt;
    gcnt_d  = gcnt;
    case (state)
      IDLE, DONE, ERROR: begin
        if (i_start) begin
          state_d = ISSUE;
          idx_d   = '0;
          retry_d = '0;
          tcnt_d  = '0;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        tcnt_d  = '0;
      end
      WAIT: begin
        // Completion takes priority over the timeout terminal count.
        if (fin_rise) begin
          retry_d = '0;
          if (idx == IW'(NUM_CMDS - 1)) begin
            state_d = DONE;
          end else begin
            state_d = GAP;
            gcnt_d  = '0;
          end
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          if (retry == RW'(MAX_RETRY)) begin
            state_d = ERROR;
          end else begin
            retry_d = retry + 1'b1;
            state_d = ISSUE;
          end
        end else begin
          tcnt_d = tcnt + 1'b1;
        end
      end
      GAP: begin
        if (gcnt == GW'(GAP_CYCLES - 1)) begin
          idx_d   = idx + 1'b1;
          state_d = ISSUE;
        end else begin
          gcnt_d = gcnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      idx         <= '0;
      retry       <= '0;
      tcnt        <= '0;
      gcnt        <= '0;
      fin_q       <= 1'b0;
      o_i2c_data  <= '0;
      o_i2c_start <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      retry       <= retry_d;
      tcnt        <= tcnt_d;
      gcnt        <= gcnt_d;
      fin_q       <= i_i2c_finished;
      // Outputs are registered from the next state so they line up with it.
      o_i2c_start <= (state_d == ISSUE);
      o_busy      <= (state_d == ISSUE) || (state_d == WAIT) || (state_d == GAP);
      o_done      <= (state_d == DONE);
      o_error     <= (state_d == ERROR);
      if (state_d == ISSUE) begin
        o_i2c_data <= CMD_TABLE[idx_d];
      end
    end
  end

endmodule
